// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter
//
// Purpose:
//   Shares one byte-serial transmitter between NUM_REQ independent byte
//   sources. A round-robin arbiter picks one pending requester when the
//   transmitter reports ready. The winner's byte is latched locally and
//   offered to the transmitter through a data/send/ready handshake. The
//   transmitter's own byte clock never enters this block; only its ready
//   flag is observed.
//
// Optional feature (compile-time macro SERIAL_TX_ARB_LOCK_EN):
//   Adds IN_LOCK. A requester that was granted last and holds its lock bit
//   (while still requesting) wins again regardless of rotation, so
//   multi-byte messages stay contiguous. Without the macro the port is
//   absent and arbitration is pure round-robin.
//
// Ports:
//   CLK           in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   IN_REQ        in   [NUM_REQ]   per-requester byte valid, held until ack
//   IN_DATA       in   [8*NUM_REQ] flattened bytes, requester i at [8i+7:8i]
//   IN_LOCK       in   [NUM_REQ]   (macro only) keep grant on last winner
//   OUT_ACK       out  [NUM_REQ]   one-cycle pulse: byte of requester latched
//   OUT_TX_DATA   out  [8]         byte to the transmitter
//   OUT_TX_SEND   out  1           send strobe to the transmitter
//   IN_TX_READY   in   1           transmitter idle/ready flag
//   OUT_GRANT_ID  out  [ID_W]      index of the last granted requester
//   OUT_BUSY      out  1           high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module serial_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [NUM_REQ-1:0]     IN_REQ,
    input  logic [8*NUM_REQ-1:0]   IN_DATA,
`ifdef SERIAL_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     IN_LOCK,
`else
`endif
    output logic [NUM_REQ-1:0]     OUT_ACK,
    output logic [7:0]             OUT_TX_DATA,
    output logic                   OUT_TX_SEND,
    input  logic                   IN_TX_READY,
    output logic [ID_W-1:0]        OUT_GRANT_ID,
    output logic                   OUT_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Registered state and outputs
    state_e               state_q,    state_d;
    logic [7:0]           data_q,     data_d;
    logic [NUM_REQ-1:0]   ack_q,      ack_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 send_q,     send_d;
    logic                 busy_q,     busy_d;

    // Arbitration helpers
    logic [ID_W-1:0]      cand_s;
    logic                 rr_hit_s;
    logic                 rr_found_s;
    logic [ID_W-1:0]      rr_id_s;
    logic                 lock_hit_s;
    logic                 win_found_s;
    logic [ID_W-1:0]      win_id_s;
    logic [7:0]           win_data_s;
    logic                 grant_s;

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            v[j] = (id == ID_W'(j));
        end
        return v;
    endfunction

    // Round-robin scan: first requesting index starting just above the last
    // grant, wrapping modulo NUM_REQ. The last granted index is visited last.
    always_comb begin
        rr_found_s = 1'b0;
        rr_id_s    = grant_id_q;
        cand_s     = grant_id_q;
        rr_hit_s   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s     = ID_W'((int'(grant_id_q) + i) % NUM_REQ);
            rr_hit_s   = !rr_found_s && (|(IN_REQ & onehot_f(cand_s)));
            rr_id_s    = rr_hit_s ? cand_s : rr_id_s;
            rr_found_s = rr_found_s | rr_hit_s;
        end
    end

`ifdef SERIAL_TX_ARB_LOCK_EN
    // Lock only matters for the last winner, and only while it still requests.
    always_comb begin
        lock_hit_s = |(IN_LOCK & IN_REQ & onehot_f(grant_id_q));
    end
`else
    // Without the lock feature the rotation is never overridden.
    always_comb begin
        lock_hit_s = 1'b0;
    end
`endif

    // Final winner selection and byte mux for the winner.
    always_comb begin
        win_found_s = lock_hit_s | rr_found_s;
        win_id_s    = lock_hit_s ? grant_id_q : rr_id_s;
        win_data_s  = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            win_data_s = win_data_s |
                         (IN_DATA[8*j +: 8] & {8{win_id_s == ID_W'(j)}});
        end
        grant_s = (state_q == ST_IDLE) && IN_TX_READY && win_found_s;
    end

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ack_d      = '0;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d    = ST_SEND;
                    data_d     = win_data_s;
                    grant_id_d = win_id_s;
                    ack_d      = onehot_f(win_id_s);
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SEND: begin
                // The transmitter may need a full byte-clock period to react;
                // keep strobing until it shows it has taken the byte.
                if (!IN_TX_READY) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT: begin
                // Return to IDLE first; arbitration happens on the next edge,
                // guaranteeing at least one idle cycle between bytes.
                if (IN_TX_READY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        send_d = (state_d == ST_SEND);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset leaves requester 0 first in line.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            data_q     <= 8'h00;
            ack_q      <= '0;
            grant_id_q <= ID_W'(NUM_REQ - 1);
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            send_q     <= send_d;
            busy_q     <= busy_d;
        end
    end

    assign OUT_ACK      = ack_q;
    assign OUT_TX_DATA  = data_q;
    assign OUT_TX_SEND  = send_q;
    assign OUT_GRANT_ID = grant_id_q;
    assign OUT_BUSY     = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_arbiter
//
// Directed bench for serial_tx_arbiter (NUM_REQ=4). The bench plays the
// transmitter by driving IN_TX_READY by hand. Lock scenario is built only
// when SERIAL_TX_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 CLK;
    logic                 RESET_N;
    logic [NUM_REQ-1:0]   IN_REQ;
    logic [8*NUM_REQ-1:0] IN_DATA;
    logic [NUM_REQ-1:0]   OUT_ACK;
    logic [7:0]           OUT_TX_DATA;
    logic                 OUT_TX_SEND;
    logic                 IN_TX_READY;
    logic [ID_W-1:0]      OUT_GRANT_ID;
    logic                 OUT_BUSY;
`ifdef SERIAL_TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   IN_LOCK;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    serial_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .IN_REQ       (IN_REQ),
        .IN_DATA      (IN_DATA),
`ifdef SERIAL_TX_ARB_LOCK_EN
        .IN_LOCK      (IN_LOCK),
`endif
        .OUT_ACK      (OUT_ACK),
        .OUT_TX_DATA  (OUT_TX_DATA),
        .OUT_TX_SEND  (OUT_TX_SEND),
        .IN_TX_READY  (IN_TX_READY),
        .OUT_GRANT_ID (OUT_GRANT_ID),
        .OUT_BUSY     (OUT_BUSY)
    );

    // 10-unit clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and settle just after the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},   32'(OUT_ACK),      32'h0);
        chk({tag, "_send"},  32'(OUT_TX_SEND),  32'h0);
        chk({tag, "_data"},  32'(OUT_TX_DATA),  32'h0);
        chk({tag, "_busy"},  32'(OUT_BUSY),     32'h0);
        chk({tag, "_grant"}, 32'(OUT_GRANT_ID), 32'd3);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        cyc(2);
        RESET_N = 1'b1;
    endtask

    // One complete byte: grant/ack, SEND held 'hold' cycles, ready low for
    // 'low' cycles, then back to IDLE. 'ghost' requesters are raised and
    // withdrawn during SEND and must never be acked.
    task automatic xfer(input string tag, input logic [ID_W-1:0] exp_id,
                        input logic [7:0] exp_data, input int hold, input int low,
                        input bit drop_req, input logic [NUM_REQ-1:0] ghost);
        int  n;
        bit  bad;
        n = 0;
        while (OUT_ACK == 4'b0000 && n < 20) begin
            cyc(1);
            n++;
        end
        chk({tag, "_ack_latency"}, 32'(n), 32'd1);
        chk({tag, "_ack"},   32'(OUT_ACK),      32'(4'b0001 << exp_id));
        chk({tag, "_data"},  32'(OUT_TX_DATA),  32'(exp_data));
        chk({tag, "_send"},  32'(OUT_TX_SEND),  32'h1);
        chk({tag, "_grant"}, 32'(OUT_GRANT_ID), 32'(exp_id));
        chk({tag, "_busy"},  32'(OUT_BUSY),     32'h1);
        if (drop_req) IN_REQ[exp_id] = 1'b0;
        IN_REQ = IN_REQ | ghost;
        bad = 1'b0;
        repeat (hold) begin
            cyc(1);
            if (OUT_ACK !== 4'b0000 || OUT_TX_SEND !== 1'b1 || OUT_TX_DATA !== exp_data)
                bad = 1'b1;
        end
        IN_REQ = IN_REQ & ~ghost;
        chk({tag, "_send_hold"}, 32'(bad), 32'h0);
        IN_TX_READY = 1'b0;
        cyc(1);
        chk({tag, "_wait_send"}, 32'(OUT_TX_SEND), 32'h0);
        chk({tag, "_wait_busy"}, 32'(OUT_BUSY),    32'h1);
        bad = 1'b0;
        repeat (low - 1) begin
            cyc(1);
            if (OUT_ACK !== 4'b0000 || OUT_TX_SEND !== 1'b0 || OUT_TX_DATA !== exp_data)
                bad = 1'b1;
        end
        chk({tag, "_wait_quiet"}, 32'(bad), 32'h0);
        IN_TX_READY = 1'b1;
        cyc(1);
        chk({tag, "_idle_busy"}, 32'(OUT_BUSY),    32'h0);
        chk({tag, "_idle_send"}, 32'(OUT_TX_SEND), 32'h0);
    endtask

    initial begin
        bit bad;
        RESET_N     = 1'b0;
        IN_REQ      = 4'b0000;
        IN_DATA     = 32'h0000_0000;
        IN_TX_READY = 1'b1;
`ifdef SERIAL_TX_ARB_LOCK_EN
        IN_LOCK     = 4'b0000;
`endif
        cyc(3);
        chk_reset_vals("reset");

        // 1: single requester 0, SEND held 20 cycles
        RESET_N = 1'b1;
        IN_REQ  = 4'b0001;
        IN_DATA = 32'h0000_0055;
        xfer("t1", 2'd0, 8'h55, 20, 5, 1'b1, 4'b0000);

        // 2: all requesting, strict rotation from requester 0
        do_reset();
        IN_DATA = 32'hA3A2_A1A0;
        IN_REQ  = 4'b1111;
        xfer("t2_b0", 2'd0, 8'hA0, 3, 30, 1'b0, 4'b0000);
        xfer("t2_b1", 2'd1, 8'hA1, 3, 30, 1'b0, 4'b0000);
        xfer("t2_b2", 2'd2, 8'hA2, 3, 30, 1'b0, 4'b0000);
        xfer("t2_b3", 2'd3, 8'hA3, 3, 30, 1'b0, 4'b0000);
        xfer("t2_b4", 2'd0, 8'hA0, 3, 30, 1'b0, 4'b0000);

        // 3: transmitter not ready for 50 cycles, then grant to 2
        IN_REQ        = 4'b0100;
        IN_TX_READY   = 1'b0;
        IN_DATA[23:16] = 8'hC2;
        bad = 1'b0;
        repeat (50) begin
            cyc(1);
            if (OUT_ACK !== 4'b0000 || OUT_TX_SEND !== 1'b0 || OUT_BUSY !== 1'b0) bad = 1'b1;
        end
        chk("t3_not_ready_quiet", 32'(bad), 32'h0);
        IN_TX_READY = 1'b1;
        xfer("t3", 2'd2, 8'hC2, 3, 5, 1'b1, 4'b0000);

        // 4: reset while in SEND with byte 3C
        IN_REQ         = 4'b1000;
        IN_DATA[31:24] = 8'h3C;
        cyc(1);
        chk("t4_ack",  32'(OUT_ACK),     32'(4'b1000));
        chk("t4_data", 32'(OUT_TX_DATA), 32'h3C);
        chk("t4_send", 32'(OUT_TX_SEND), 32'h1);
        cyc(3);
        RESET_N = 1'b0;
        #1;
        chk_reset_vals("t4_mid_reset");
        IN_REQ = 4'b0000;
        cyc(2);
        RESET_N = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            cyc(1);
            if (OUT_ACK !== 4'b0000 || OUT_BUSY !== 1'b0) bad = 1'b1;
        end
        chk("t4_no_ack_after_reset", 32'(bad), 32'h0);

        // 5: requester 1 withdraws before grant while 3 transmits
        IN_REQ         = 4'b1000;
        IN_DATA[31:24] = 8'hD3;
        xfer("t5_b0", 2'd3, 8'hD3, 5, 5, 1'b0, 4'b0010);
        IN_DATA[31:24] = 8'hE3;
        xfer("t5_b1", 2'd3, 8'hE3, 3, 3, 1'b1, 4'b0000);
        bad = 1'b0;
        repeat (5) begin
            cyc(1);
            if (OUT_ACK !== 4'b0000 || OUT_BUSY !== 1'b0) bad = 1'b1;
        end
        chk("t5_bus_idle", 32'(bad), 32'h0);

`ifdef SERIAL_TX_ARB_LOCK_EN
        // 6: locked requester 2 keeps the transmitter for three bytes
        do_reset();
        IN_REQ         = 4'b0100;
        IN_LOCK        = 4'b0100;
        IN_DATA        = 32'h0022_0010;
        xfer("t6_b0", 2'd2, 8'h22, 3, 5, 1'b0, 4'b0000);
        IN_REQ         = 4'b0101;
        IN_DATA[23:16] = 8'h23;
        xfer("t6_b1", 2'd2, 8'h23, 3, 5, 1'b0, 4'b0000);
        IN_DATA[23:16] = 8'h24;
        xfer("t6_b2", 2'd2, 8'h24, 3, 5, 1'b1, 4'b0000);
        IN_LOCK        = 4'b0000;
        xfer("t6_b3", 2'd0, 8'h10, 3, 5, 1'b1, 4'b0000);
`endif

        if (fail_cnt != 0) $display("%0d comparisons did not match", fail_cnt);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
